// File: rtl/mealy_seq_pkg.sv
// Shared types and default widths for the Mealy detector sequencer.
// The optional loop feature (MEALY_SEQ_LOOP_EN) is handled in the top module.
package mealy_seq_pkg;

  localparam int DEF_PAT_W = 8;
  localparam int DEF_LEN_W = 4;
  localparam int DEF_CNT_W = 4;

  localparam logic [DEF_CNT_W-1:0] DEF_CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RST  = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } seq_state_e;

endpackage

// File: rtl/mealy_seq_ctrl_if.sv
// Host-side bus of the sequencer: configuration, start/busy/done handshake and results.
// The master modport belongs to the host; the slave modport belongs to the sequencer.
interface mealy_seq_ctrl_if #(
  parameter int PAT_W = 8,
  parameter int LEN_W = 4,
  parameter int CNT_W = 4
);
  logic             cfg_valid;
  logic [PAT_W-1:0] cfg_pat;
  logic [LEN_W-1:0] cfg_len;
  logic             start;
  logic             busy;
  logic             done;
  logic [PAT_W-1:0] z_trace;
  logic [CNT_W-1:0] hit_cnt;

  modport master (
    output cfg_valid, cfg_pat, cfg_len, start,
    input  busy, done, z_trace, hit_cnt
  );

  modport slave (
    input  cfg_valid, cfg_pat, cfg_len, start,
    output busy, done, z_trace, hit_cnt
  );
endinterface

// File: rtl/mealy_seq_sat_cnt.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
// Clear has priority over increment.
module mealy_seq_sat_cnt #(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [CNT_W-1:0] cnt_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mealy_seq_ctrl.sv
// Sequencer that resets the serial Mealy detector, streams a pattern LSB first and records its output.
// Define MEALY_SEQ_LOOP_EN to add the loop input (DONE re-enters RST while loop is high).
//
// state | meaning
// IDLE  | waiting for start; cfg_valid latches pattern/length
// RST   | detector held in reset for one cycle
// RUN   | one pattern bit per cycle on fsm_x, fsm_z sampled each edge
// DONE  | one-cycle done pulse
module mealy_seq_ctrl
  import mealy_seq_pkg::*;
#(
  parameter int PAT_W = DEF_PAT_W,
  parameter int LEN_W = DEF_LEN_W,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
`ifdef MEALY_SEQ_LOOP_EN
  input  logic                 loop,
`endif
  mealy_seq_ctrl_if.slave      bus,
  output logic                 fsm_rst_n,
  output logic                 fsm_x,
  input  logic                 fsm_z
);

  localparam int IDX_W = (PAT_W > 1) ? $clog2(PAT_W) : 1;

  seq_state_e       state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] idx_q, idx_d;
  logic [PAT_W-1:0] z_trace_q, z_trace_d;
  logic             cnt_clr, cnt_inc;
  logic             busy, done;
  logic             loop_en;

`ifdef MEALY_SEQ_LOOP_EN
  assign loop_en = loop;
`else
  assign loop_en = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    len_d     = len_q;
    idx_d     = idx_q;
    z_trace_d = z_trace_q;
    cnt_clr   = 1'b0;
    cnt_inc   = 1'b0;
    fsm_x     = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.cfg_valid) begin
          pat_d = bus.cfg_pat;
          len_d = (bus.cfg_len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.cfg_len;
        end
        if (bus.start) begin
          state_d   = RST;
          z_trace_d = '0;
          idx_d     = '0;
          cnt_clr   = 1'b1;
        end
      end
      RST: begin
        busy    = 1'b1;
        idx_d   = '0;
        state_d = (len_q == '0) ? DONE : RUN;
      end
      RUN: begin
        busy    = 1'b1;
        fsm_x   = pat_q[idx_q[IDX_W-1:0]];
        z_trace_d[idx_q[IDX_W-1:0]] = fsm_z;
        cnt_inc = fsm_z;
        idx_d   = idx_q + LEN_W'(1);
        if (idx_q == len_q - LEN_W'(1)) state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        // looping keeps hit_cnt accumulating; z_trace is simply overwritten next pass
        state_d = loop_en ? RST : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pat_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      z_trace_q <= '0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      z_trace_q <= z_trace_d;
    end
  end

  mealy_seq_sat_cnt #(.CNT_W(CNT_W)) u_hit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (cnt_clr),
    .inc_i (cnt_inc),
    .cnt_o (bus.hit_cnt)
  );

  // detector also sits in reset whenever the sequencer itself is reset
  assign fsm_rst_n   = rst_n & (state_q != RST);
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.z_trace = z_trace_q;

endmodule

// File: doc/mealy_seq_ctrl.md
# mealy_seq_ctrl

Sequencer that drives the team's 5-state serial Mealy detector as a test/exercise datapath. It latches a bit pattern and length, resets the detector, streams the pattern into the detector's serial input one bit per cycle (LSB first), and samples the detector's ungated Mealy output on each bit. It reports a per-bit output trace and a saturating hit count with a start/busy/done handshake. It sits between the tile's input pins and the detector instance.

## Interface
- PAT_W, 8: maximum pattern length in bits.
- LEN_W, 4: width of length field; must satisfy 2**LEN_W > PAT_W.
- CNT_W, 4: hit counter width.

Ports (reset rst_n, synchronous, active-low; clock clk):
- clk  in  1  clock.
- rst_n  in  1  synchronous active-low reset.
- cfg_valid  in  1  latch cfg_pat/cfg_len this cycle (IDLE only).
- cfg_pat  in  PAT_W  pattern; bit i is applied at step i.
- cfg_len  in  LEN_W  number of bits to apply.
- start  in  1  begin a run (IDLE only).
- busy  out  1  high in RST and RUN states.
- done  out  1  one-cycle pulse in DONE state.
- fsm_rst_n  out  1  active-low reset to detector.
- fsm_x  out  1  serial input to detector.
- fsm_z  in  1  detector Mealy output (ungated), combinational on current state and fsm_x.
- z_trace  out  PAT_W  bit i = fsm_z sampled at step i.
- hit_cnt  out  CNT_W  count of steps with fsm_z=1, saturating.
- loop  in  1  only present with MEALY_SEQ_LOOP_EN.

## Operation
- States: IDLE, RST, RUN, DONE.
- IDLE: cfg_valid latches pat_q, len_q (len clamped to PAT_W). start -> RST; clears z_trace, hit_cnt, idx. If start and cfg_valid are both high, the new config is latched and used by this run.
- RST: fsm_rst_n=0 for exactly one cycle. Next state is RUN, or DONE if len_q=0.
- RUN: fsm_x = pat_q[idx]. At each edge: z_trace[idx] <= fsm_z; hit_cnt += fsm_z (holds at 2**CNT_W-1); idx++. After step len_q-1 -> DONE.
- DONE: done=1 for one cycle -> IDLE.
- Outside RUN, fsm_x=0. fsm_rst_n = rst_n & (state!=RST).
- start and cfg_valid are ignored outside IDLE.
- z_trace and hit_cnt hold from DONE until the next start.
- z_trace bits at or above len_q read 0.

## Timing
- Reset values: state IDLE, busy 0, done 0, fsm_x 0, fsm_rst_n 0 (follows rst_n), z_trace 0, hit_cnt 0, pat_q 0, len_q 0.
- Start sampled at edge E:
  - RST occupies the cycle after E.
  - Step i is applied in the cycle after edge E+1+i and sampled at edge E+2+i.
  - done is high in the cycle after edge E+1+len_q.
- len_q=0: done is high in the cycle after E+1; hit_cnt=0.
- A new start is accepted the cycle after done (IDLE).
- rst_n low mid-run: state returns to IDLE at that edge, all outputs take reset values, and the detector is held reset.

## Configuration
- MEALY_SEQ_LOOP_EN defined:
  - loop port exists.
  - On leaving RUN with loop=1, done pulses and the next state is RST instead of IDLE.
  - hit_cnt keeps accumulating (saturating) across loops; z_trace is overwritten per pass.
  - loop=0 at DONE returns to IDLE.
- Undefined: no loop port; DONE always -> IDLE.

## Structure
- Package mealy_seq_pkg: state enum (IDLE, RST, RUN, DONE), default widths PAT_W/LEN_W/CNT_W, max-count constant.
- One sub-module: mealy_seq_sat_cnt (CNT_W saturating counter with clear and increment).
- Bench instantiates the detector (odd-parity-per-3-bit-group behaviour: fsm_z=1 only at the 3rd bit of a group with odd parity).

## Test plan
- cfg_pat=8'h04, cfg_len=3, start -> busy for 4 cycles, done 5 cycles after start edge, z_trace=8'h04, hit_cnt=1.
- cfg_pat=8'h3C, cfg_len=6 -> z_trace=8'h24, hit_cnt=2.
- cfg_pat=8'h18, cfg_len=6 -> z_trace=8'h00, hit_cnt=0.
- cfg_len=0, start -> fsm_rst_n low 1 cycle, done in cycle after E+1, hit_cnt=0; then start asserted while busy in a len=6 run -> ignored, single done pulse.
- rst_n low during step 2 of an 8'h3C/6 run -> next cycle IDLE, busy=0, hit_cnt=0, z_trace=0, fsm_rst_n=0 while rst_n low.
- With MEALY_SEQ_LOOP_EN: pattern 8'h04/3, loop=1 for 20 passes -> done pulses every 5 cycles, hit_cnt saturates at 15.
